// File: rtl/render_pkg.sv
//------------------------------------------------------------------------------
// Module   : render_pkg
// Desc     : Shared types and constants for the rectangle-renderer chain:
//            token width, shape register IDs, command record, scan states.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package render_pkg;

  localparam int TOKEN_W = 12;
  localparam int CMD_W   = 3 * TOKEN_W;

  // Shape register IDs carried in y_out of a programming token
  localparam logic [TOKEN_W-1:0] REG_X     = 12'd0;
  localparam logic [TOKEN_W-1:0] REG_Y     = 12'd1;
  localparam logic [TOKEN_W-1:0] REG_W     = 12'd2;
  localparam logic [TOKEN_W-1:0] REG_H     = 12'd3;
  localparam logic [TOKEN_W-1:0] REG_COLOR = 12'd4;

  // Host command as stored in the FIFO; shape occupies the top bits
  typedef struct packed {
    logic [TOKEN_W-1:0] shape;
    logic [TOKEN_W-1:0] reg_id;
    logic [TOKEN_W-1:0] data;
  } cmd_t;

  typedef enum logic [1:0] {
    SCAN_ACTIVE = 2'd0,
    SCAN_HBLANK = 2'd1,
    SCAN_VBLANK = 2'd2
  } scan_e;

endpackage

`default_nettype wire

// File: rtl/cmd_fifo.sv
//------------------------------------------------------------------------------
// Module   : cmd_fifo
// Desc     : Synchronous command FIFO. Storage and occupancy are registered;
//            the head entry is presented from the storage array so the
//            consumer can register it in the same cycle it pops. Ready is a
//            registered not-full flag that is low throughout reset.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cmd_fifo #(
  parameter  int WIDTH = 36,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty,
  output logic             o_ready,
  output logic [LW-1:0]    o_level
);

  localparam logic [LW-1:0] c_FULL = LW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             r_ready;

  logic             w_push;
  logic             w_pop;
  logic [LW-1:0]    w_level_nxt;

  // Qualify requests: push only when ready, pop only when occupied
  always_comb begin
    w_push      = i_push && r_ready;
    w_pop       = i_pop && (r_level != '0);
    w_level_nxt = r_level + LW'(w_push) - LW'(w_pop);
  end

  // Payload storage; occupancy gates every read so it needs no reset
  always_ff @(posedge clk) begin
    if (rst_n && w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers, occupancy and the registered not-full flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ready  <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level <= w_level_nxt;
      r_ready <= (w_level_nxt != c_FULL);
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_empty = (r_level == '0);
  assign o_ready = r_ready;
  assign o_level = r_level;

endmodule

`default_nettype wire

// File: rtl/render_stream_source.sv
//------------------------------------------------------------------------------
// Module   : render_stream_source
// Desc     : Head of the rectangle-renderer chain. Emits one raster token per
//            cycle (x, y, background colour) and, during blanking, replaces
//            blanking slots with programming tokens drawn from the host
//            command FIFO.
//            Build option RSS_HBLANK_INJECT_EN: also inject during horizontal
//            blanking (lower latency, shapes may change mid-frame).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module render_stream_source
  import render_pkg::*;
#(
  parameter  int                 H_ACTIVE   = 640,
  parameter  int                 H_BLANK    = 160,
  parameter  int                 V_ACTIVE   = 480,
  parameter  int                 V_BLANK    = 45,
  parameter  int                 FIFO_DEPTH = 16,
  parameter  logic [TOKEN_W-1:0] BG_COLOR   = 12'h000,
  localparam int                 LW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [TOKEN_W-1:0] cmd_shape,
  input  logic [TOKEN_W-1:0] cmd_reg,
  input  logic [TOKEN_W-1:0] cmd_data,
  output logic               program_out,
  output logic [TOKEN_W-1:0] x_out,
  output logic [TOKEN_W-1:0] y_out,
  output logic [TOKEN_W-1:0] data_out,
  output logic               frame_start,
  output logic [LW-1:0]      fifo_level
);

  localparam logic [TOKEN_W-1:0] c_H_ACTIVE = TOKEN_W'(H_ACTIVE);
  localparam logic [TOKEN_W-1:0] c_H_LAST   = TOKEN_W'(H_ACTIVE + H_BLANK - 1);
  localparam logic [TOKEN_W-1:0] c_V_ACTIVE = TOKEN_W'(V_ACTIVE);
  localparam logic [TOKEN_W-1:0] c_V_LAST   = TOKEN_W'(V_ACTIVE + V_BLANK - 1);

  logic [TOKEN_W-1:0] r_hcount;
  logic [TOKEN_W-1:0] r_vcount;
  scan_e              r_scan;

  logic [TOKEN_W-1:0] w_hcount_nxt;
  logic [TOKEN_W-1:0] w_vcount_nxt;
  scan_e              w_scan_nxt;
  logic               w_window;
  logic               w_pop;
  logic               w_empty;
  logic [CMD_W-1:0]   w_rdata;
  cmd_t               w_head;
  cmd_t               w_wcmd;

  // Raster position and scan state register; free-running, never stalls
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hcount <= '0;
      r_vcount <= '0;
      r_scan   <= SCAN_ACTIVE;
    end else begin
      r_hcount <= w_hcount_nxt;
      r_vcount <= w_vcount_nxt;
      r_scan   <= w_scan_nxt;
    end
  end

  // Next raster position and the scan state it falls into
  always_comb begin
    w_hcount_nxt = r_hcount + 12'd1;
    w_vcount_nxt = r_vcount;
    w_scan_nxt   = SCAN_ACTIVE;
    if (r_hcount == c_H_LAST) begin
      w_hcount_nxt = '0;
      w_vcount_nxt = (r_vcount == c_V_LAST) ? '0 : r_vcount + 12'd1;
    end
    if (w_vcount_nxt >= c_V_ACTIVE) begin
      w_scan_nxt = SCAN_VBLANK;
    end else if (w_hcount_nxt >= c_H_ACTIVE) begin
      w_scan_nxt = SCAN_HBLANK;
    end
  end

  // Injection window: slots that may be replaced by a programming token
  always_comb begin
`ifdef RSS_HBLANK_INJECT_EN
    w_window = (r_scan != SCAN_ACTIVE);
`else
    w_window = (r_scan == SCAN_VBLANK);
`endif
    w_pop = w_window && !w_empty;
  end

  assign w_wcmd = '{shape: cmd_shape, reg_id: cmd_reg, data: cmd_data};
  assign w_head = cmd_t'(w_rdata);

  cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (cmd_valid),
    .i_wdata (w_wcmd),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_empty (w_empty),
    .o_ready (cmd_ready),
    .o_level (fifo_level)
  );

  // Output token register: programming token when popping, else pixel token
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      program_out <= 1'b0;
      x_out       <= '0;
      y_out       <= '0;
      data_out    <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= (r_hcount == '0) && (r_vcount == '0);
      if (w_pop) begin
        program_out <= 1'b1;
        x_out       <= w_head.shape;
        y_out       <= w_head.reg_id;
        data_out    <= w_head.data;
      end else begin
        program_out <= 1'b0;
        x_out       <= r_hcount;
        y_out       <= r_vcount;
        data_out    <= BG_COLOR;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_render_stream_source.sv
//------------------------------------------------------------------------------
// Module   : tb_render_stream_source
// Desc     : Self-checking bench for render_stream_source with a small raster
//            (4+2 pixels x 3+2 lines). Table vectors, directed sequences and
//            randomized traffic against a position/queue reference model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_render_stream_source;

  localparam int          HA    = 4;
  localparam int          HB    = 2;
  localparam int          VA    = 3;
  localparam int          VB    = 2;
  localparam int          HT    = HA + HB;
  localparam int          FT    = HT * (VA + VB);
  localparam int          DEPTH = 16;
  localparam logic [11:0] BG    = 12'h0A5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [11:0] cmd_shape = '0;
  logic [11:0] cmd_reg = '0;
  logic [11:0] cmd_data = '0;
  logic        program_out;
  logic [11:0] x_out;
  logic [11:0] y_out;
  logic [11:0] data_out;
  logic        frame_start;
  logic [4:0]  fifo_level;

  render_stream_source #(
    .H_ACTIVE   (HA),
    .H_BLANK    (HB),
    .V_ACTIVE   (VA),
    .V_BLANK    (VB),
    .FIFO_DEPTH (DEPTH),
    .BG_COLOR   (BG)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_shape   (cmd_shape),
    .cmd_reg     (cmd_reg),
    .cmd_data    (cmd_data),
    .program_out (program_out),
    .x_out       (x_out),
    .y_out       (y_out),
    .data_out    (data_out),
    .frame_start (frame_start),
    .fifo_level  (fifo_level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: raster slot index and a queue of pending commands
  logic [35:0] q[$];
  int          p = 0;
  logic        m_prog = 1'b0;
  logic        m_fs = 1'b0;
  logic        m_ready = 1'b0;
  logic [11:0] m_x = '0;
  logic [11:0] m_y = '0;
  logic [11:0] m_data = '0;
  int          m_level = 0;

  typedef struct {
    logic        rn;
    logic        v;
    logic [11:0] s;
    logic [11:0] r;
    logic [11:0] d;
    logic        prog;
    logic [11:0] x;
    logic [11:0] y;
    logic [11:0] dat;
    logic        fs;
    logic        rdy;
    logic [4:0]  lvl;
  } vec_t;

  vec_t        tbl[6];
  int          accepted;
  int          guard;
  int          cnt;
  logic        rdy_before;
  bit          seen_full;
  logic [11:0] got[$];

  function automatic bit win(input int pos);
    int h;
    int v;
    h = pos % HT;
    v = pos / HT;
`ifdef RSS_HBLANK_INJECT_EN
    return (v >= VA) || (h >= HA);
`else
    return (v >= VA);
`endif
  endfunction

  function automatic logic [63:0] tok();
    return 64'({program_out, x_out, y_out, data_out});
  endfunction

  function automatic logic [63:0] etok(input logic pr, input logic [11:0] x, y, d);
    return 64'({pr, x, y, d});
  endfunction

  function automatic logic [63:0] dut_vec();
    return 64'({program_out, x_out, y_out, data_out, frame_start, cmd_ready, fifo_level});
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_update(input logic rn, input logic v, input logic [11:0] s, r, d);
    logic [35:0] item;
    if (!rn) begin
      q.delete();
      p = 0;
      m_prog = 1'b0; m_x = '0; m_y = '0; m_data = '0; m_fs = 1'b0;
      m_ready = 1'b0; m_level = 0;
    end else begin
      m_fs = (p == 0);
      if (win(p) && q.size() > 0) begin
        item   = q.pop_front();
        m_prog = 1'b1;
        m_x    = item[35:24];
        m_y    = item[23:12];
        m_data = item[11:0];
      end else begin
        m_prog = 1'b0;
        m_x    = 12'(p % HT);
        m_y    = 12'(p / HT);
        m_data = BG;
      end
      if (v && m_ready) q.push_back({s, r, d});
      p       = (p + 1) % FT;
      m_ready = (q.size() < DEPTH);
      m_level = q.size();
    end
  endtask

  // One clock: drive inputs, sample 1 time unit after the edge, compare to model
  task automatic step(input logic rn, input logic v, input logic [11:0] s, r, d);
    rst_n = rn; cmd_valid = v; cmd_shape = s; cmd_reg = r; cmd_data = d;
    @(posedge clk);
    #1;
    model_update(rn, v, s, r, d);
    check("model", dut_vec(),
          64'({m_prog, m_x, m_y, m_data, m_fs, m_ready, 5'(m_level)}));
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 12'd0, 12'd0, 12'd0);
  endtask

  initial begin
    // ---------------- table: reset and first tokens --------------------
    tbl[0] = '{1'b0, 1'b0, 12'd0, 12'd0, 12'd0,     1'b0, 12'd0, 12'd0, 12'd0, 1'b0, 1'b0, 5'd0};
    tbl[1] = '{1'b0, 1'b0, 12'd0, 12'd0, 12'd0,     1'b0, 12'd0, 12'd0, 12'd0, 1'b0, 1'b0, 5'd0};
    tbl[2] = '{1'b1, 1'b0, 12'd0, 12'd0, 12'd0,     1'b0, 12'd0, 12'd0, BG,    1'b1, 1'b1, 5'd0};
    tbl[3] = '{1'b1, 1'b1, 12'd2, 12'd4, 12'hF00,   1'b0, 12'd1, 12'd0, BG,    1'b0, 1'b1, 5'd1};
    tbl[4] = '{1'b1, 1'b0, 12'd0, 12'd0, 12'd0,     1'b0, 12'd2, 12'd0, BG,    1'b0, 1'b1, 5'd1};
    tbl[5] = '{1'b1, 1'b0, 12'd0, 12'd0, 12'd0,     1'b0, 12'd3, 12'd0, BG,    1'b0, 1'b1, 5'd1};
    for (int i = 0; i < 6; i++) begin
      step(tbl[i].rn, tbl[i].v, tbl[i].s, tbl[i].r, tbl[i].d);
      check($sformatf("vec%0d", i), dut_vec(),
            64'({tbl[i].prog, tbl[i].x, tbl[i].y, tbl[i].dat, tbl[i].fs, tbl[i].rdy, tbl[i].lvl}));
    end

    // ---------------- pending command emerges at first window slot -----
    // Edge e (1-based after reset release) carries raster slot e-1.
`ifdef RSS_HBLANK_INJECT_EN
    idle();
    check("inject_tok", tok(), etok(1'b1, 12'd2, 12'd4, 12'hF00));
    idle();
    check("resume", tok(), etok(1'b0, 12'd5, 12'd0, BG));
    for (int e = 7; e <= 30; e++) idle();
`else
    for (int e = 5; e <= 18; e++) begin
      idle();
      check("pixel_wait", tok(), etok(1'b0, 12'((e - 1) % HT), 12'((e - 1) / HT), BG));
    end
    idle();
    check("inject_tok", tok(), etok(1'b1, 12'd2, 12'd4, 12'hF00));
    idle();
    check("resume", tok(), etok(1'b0, 12'd1, 12'd3, BG));
    for (int e = 21; e <= 30; e++) idle();
`endif
    idle();
    check("frame_start_again", 64'({frame_start, x_out, y_out}), 64'({1'b1, 12'd0, 12'd0}));

    // ---------------- 20 back-to-back commands --------------------------
    accepted  = 0;
    guard     = 0;
    seen_full = 1'b0;
    got.delete();
    while (accepted < 20 && guard < 300) begin
      rdy_before = m_ready;
      step(1'b1, 1'b1, 12'(accepted), 12'(accepted % 8), 12'h100 + 12'(accepted));
      if (program_out) got.push_back(data_out);
      if (rdy_before) accepted++;
`ifndef RSS_HBLANK_INJECT_EN
      if (accepted == 16 && !seen_full) begin
        seen_full = 1'b1;
        check("full_ready", 64'(cmd_ready), 64'(1'b0));
        check("full_level", 64'(fifo_level), 64'(5'd16));
      end
`endif
      guard++;
    end
    check("push_all", 64'(accepted), 64'(20));
    for (int i = 0; i < 100; i++) begin
      idle();
      if (program_out) got.push_back(data_out);
    end
    check("drain_count", 64'(got.size()), 64'(20));
    for (int i = 0; i < got.size() && i < 20; i++) begin
      check($sformatf("drain_order%0d", i), 64'(got[i]), 64'(12'h100 + 12'(i)));
    end

    // ---------------- reset while commands are pending ------------------
    guard = 0;
    while (p != 0 && guard < 2 * FT) begin
      idle();
      guard++;
    end
    check("align_frame", 64'(p), 64'(0));
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 12'd9, 12'd1, 12'h300 + 12'(i));
    check("pending_level", 64'(fifo_level), 64'(5'd3));
    step(1'b0, 1'b0, 12'd0, 12'd0, 12'd0);
    check("rst_level", 64'(fifo_level), 64'(5'd0));
    check("rst_out", 64'({tok(), frame_start, cmd_ready}), 64'(0));
    cnt = 0;
    for (int i = 0; i < FT; i++) begin
      idle();
      if (program_out) cnt++;
    end
    check("no_stale_inject", 64'(cnt), 64'(0));

    // ---------------- simultaneous push and pop at level 1 --------------
    guard = 0;
    while (!(!win(p) && win((p + 1) % FT)) && guard < 2 * FT) begin
      idle();
      guard++;
    end
    check("find_edge", 64'({win(p), win((p + 1) % FT)}), 64'(2'b01));
    step(1'b1, 1'b1, 12'd7, 12'd1, 12'hAAA);
    check("simul_pre_level", 64'(fifo_level), 64'(5'd1));
    step(1'b1, 1'b1, 12'd8, 12'd2, 12'hBBB);
    check("simul_level", 64'(fifo_level), 64'(5'd1));
    check("simul_tok", tok(), etok(1'b1, 12'd7, 12'd1, 12'hAAA));
    for (int i = 0; i < FT; i++) idle();

    // ---------------- randomized traffic against the model --------------
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 299) != 0),
           ($urandom_range(0, 3) != 0),
           12'($urandom), 12'($urandom_range(0, 7)), 12'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
